// File: rtl/keycode_event_queue.sv
// Turns a level keycode into press/release/repeat events queued in a 4-entry FIFO.
// Latency: press event visible one edge after the FSM leaves IDLE; release then press on consecutive edges.
// Backpressure: none toward the FSM; evt_ready only pops, and a push onto a full FIFO is dropped and flagged.
module keycode_event_queue #(
    parameter int unsigned REPEAT_DELAY  = 1000,  // 1..65535
    parameter int unsigned REPEAT_PERIOD = 250    // 1..REPEAT_DELAY
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] key_code,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [9:0] evt_data,
    output logic [7:0] held_code,
    output logic [3:0] dir,
    output logic       overflow,
    input  logic       overflow_clr
);

    // Event type field in evt_data[9:8].
    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_RELEASE = 2'b10;
    localparam logic [1:0] EVT_REPEAT  = 2'b11;

    // The counter fires at DELAY-1, then restarts at DELAY-PERIOD so the next
    // fire lands exactly PERIOD cycles later.
    localparam logic [15:0] LP_FIRE   = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] LP_RELOAD = 16'(REPEAT_DELAY - REPEAT_PERIOD);

    // Movement-key codes decoded onto dir = {W, A, S, D}.
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RELEASE = 2'd1,
        PRESS   = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t      r_state;
    logic [7:0]  r_pending;
    logic [7:0]  r_held;
    logic [15:0] r_rep_cnt;

    logic        w_key_same;
    logic        w_push;
    logic [9:0]  w_push_dat;

    logic [9:0]  r_mem [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;
    logic        r_overflow;

    logic        w_full;
    logic        w_pop;
    logic        w_wr;
    logic        w_drop;
    logic [3:0]  w_dir;

    assign w_key_same = (key_code == r_held);

    // Key tracking FSM; key_code is only looked at in IDLE and HOLD, so changes
    // during RELEASE/PRESS are picked up by the next HOLD/IDLE compare.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_pending <= 8'h00;
            r_held    <= 8'h00;
            r_rep_cnt <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (key_code != 8'h00) begin
                        r_pending <= key_code;
                        r_state   <= PRESS;
                    end
                end
                PRESS: begin
                    r_held    <= r_pending;
                    r_rep_cnt <= 16'h0000;
                    r_state   <= HOLD;
                end
                HOLD: begin
                    if (!w_key_same) begin
                        r_pending <= key_code;
                        r_state   <= RELEASE;
                    end else if (r_rep_cnt == LP_FIRE) begin
                        r_rep_cnt <= LP_RELOAD;
                    end else begin
                        r_rep_cnt <= r_rep_cnt + 16'd1;
                    end
                end
                RELEASE: begin
                    r_held  <= 8'h00;
                    r_state <= (r_pending != 8'h00) ? PRESS : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Event generation is decoded from the current state so the FIFO is written
    // on the same edge the FSM performs the matching transition.
    always_comb begin
        w_push     = 1'b0;
        w_push_dat = 10'h000;
        case (r_state)
            PRESS: begin
                w_push     = 1'b1;
                w_push_dat = {EVT_PRESS, r_pending};
            end
            RELEASE: begin
                w_push     = 1'b1;
                w_push_dat = {EVT_RELEASE, r_held};
            end
            HOLD: begin
                if (w_key_same && (r_rep_cnt == LP_FIRE)) begin
                    w_push     = 1'b1;
                    w_push_dat = {EVT_REPEAT, r_held};
                end
            end
            default: begin
                w_push     = 1'b0;
                w_push_dat = 10'h000;
            end
        endcase
    end

    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign w_full = (r_count == 3'd4);
    assign w_pop  = evt_valid && evt_ready;
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    // FIFO pointers and occupancy; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents need no reset since occupancy governs visibility.
    always_ff @(posedge clk) begin
        if (reset_n && w_wr) begin
            r_mem[r_wr_ptr] <= w_push_dat;
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // Direction decode from the held register, so dir moves with held_code.
    always_comb begin
        w_dir = 4'b0000;
        case (r_held)
            KEY_W:   w_dir = 4'b1000;
            KEY_A:   w_dir = 4'b0100;
            KEY_S:   w_dir = 4'b0010;
            KEY_D:   w_dir = 4'b0001;
            default: w_dir = 4'b0000;
        endcase
    end

    assign evt_valid = (r_count != 3'd0);
    assign evt_data  = (reset_n && evt_valid) ? r_mem[r_rd_ptr] : 10'h000;
    assign held_code = r_held;
    assign dir       = w_dir;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_keycode_event_queue.sv
// Directed bench for keycode_event_queue with a short repeat timing.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Every expected value below is worked out by hand from the event timing.
module tb_keycode_event_queue;

    logic       clk;
    logic       reset_n;
    logic [7:0] key_code;
    logic       evt_valid;
    logic       evt_ready;
    logic [9:0] evt_data;
    logic [7:0] held_code;
    logic [3:0] dir;
    logic       overflow;
    logic       overflow_clr;

    int n_checks = 0;
    int n_pass   = 0;

    keycode_event_queue #(
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_code    (key_code),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_data    (evt_data),
        .held_code   (held_code),
        .dir         (dir),
        .overflow    (overflow),
        .overflow_clr(overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        key_code     = 8'h00;
        evt_ready    = 1'b1;
        overflow_clr = 1'b0;
        step(2);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        key_code     = 8'h00;
        evt_ready    = 1'b0;
        overflow_clr = 1'b0;
        step(2);
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", evt_valid); else n_pass++;
        n_checks++; if (evt_data !== 10'h000) $display("FAIL reset_data got %h want 000", evt_data); else n_pass++;
        n_checks++; if (held_code !== 8'h00) $display("FAIL reset_held got %h want 00", held_code); else n_pass++;
        n_checks++; if (dir !== 4'b0000) $display("FAIL reset_dir got %b want 0000", dir); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow); else n_pass++;
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic test_press_repeat();
        do_reset();
        key_code = 8'h1A;
        step(1);  // E0: IDLE -> PRESS
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL press_e0_valid got %b want 0", evt_valid); else n_pass++;
        step(1);  // E1: press pushed
        n_checks++; if (evt_valid !== 1'b1 || evt_data !== 10'h11A) $display("FAIL press_e1 got v=%b d=%h want v=1 d=11a", evt_valid, evt_data); else n_pass++;
        n_checks++; if (held_code !== 8'h1A) $display("FAIL press_held got %h want 1a", held_code); else n_pass++;
        n_checks++; if (dir !== 4'b1000) $display("FAIL press_dir got %b want 1000", dir); else n_pass++;
        step(7);  // E8: press popped long ago, no repeat yet
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL repeat_early got %b want 0", evt_valid); else n_pass++;
        step(1);  // E9: first repeat, 8 cycles into HOLD
        n_checks++; if (evt_valid !== 1'b1 || evt_data !== 10'h31A) $display("FAIL repeat_first got v=%b d=%h want v=1 d=31a", evt_valid, evt_data); else n_pass++;
        step(2);  // E11
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL repeat_gap got %b want 0", evt_valid); else n_pass++;
        step(1);  // E12: second repeat, 3 cycles later
        n_checks++; if (evt_valid !== 1'b1 || evt_data !== 10'h31A) $display("FAIL repeat_second got v=%b d=%h want v=1 d=31a", evt_valid, evt_data); else n_pass++;
    endtask

    task automatic test_release_press();
        do_reset();
        key_code = 8'h1A;
        step(3);  // press pushed at E1, popped at E2
        key_code = 8'h04;
        step(1);  // E3: HOLD -> RELEASE
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL chg_e0_valid got %b want 0", evt_valid); else n_pass++;
        step(1);  // E4: release pushed
        n_checks++; if (evt_valid !== 1'b1 || evt_data !== 10'h21A) $display("FAIL chg_release got v=%b d=%h want v=1 d=21a", evt_valid, evt_data); else n_pass++;
        n_checks++; if (held_code !== 8'h00 || dir !== 4'b0000) $display("FAIL chg_mid_held got %h/%b want 00/0000", held_code, dir); else n_pass++;
        step(1);  // E5: press pushed, release popped
        n_checks++; if (evt_valid !== 1'b1 || evt_data !== 10'h104) $display("FAIL chg_press got v=%b d=%h want v=1 d=104", evt_valid, evt_data); else n_pass++;
        n_checks++; if (held_code !== 8'h04 || dir !== 4'b0100) $display("FAIL chg_dir got %h/%b want 04/0100", held_code, dir); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [9:0] exp_q [4];
        exp_q = '{10'h11A, 10'h21A, 10'h104, 10'h204};
        do_reset();
        evt_ready = 1'b0;
        key_code  = 8'h1A; step(2);  // P1A
        key_code  = 8'h04; step(3);  // R1A, P04
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_early got %b want 0", overflow); else n_pass++;
        key_code  = 8'h07; step(3);  // R04 fills, P07 dropped
        key_code  = 8'h00; step(2);  // R07 dropped
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow); else n_pass++;
        n_checks++; if (evt_valid !== 1'b1 || evt_data !== 10'h11A) $display("FAIL ovf_head got v=%b d=%h want v=1 d=11a", evt_valid, evt_data); else n_pass++;
        overflow_clr = 1'b1; step(1); overflow_clr = 1'b0;
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clr got %b want 0", overflow); else n_pass++;
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (evt_valid !== 1'b1 || evt_data !== exp_q[i]) $display("FAIL ovf_drain%0d got v=%b d=%h want v=1 d=%h", i, evt_valid, evt_data, exp_q[i]); else n_pass++;
            step(1);
        end
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL ovf_empty got %b want 0", evt_valid); else n_pass++;
    endtask

    task automatic test_full_pop();
        logic [9:0] exp_q [4];
        exp_q = '{10'h21A, 10'h104, 10'h204, 10'h107};
        do_reset();
        evt_ready = 1'b0;
        key_code  = 8'h1A; step(2);  // P1A
        key_code  = 8'h04; step(3);  // R1A, P04
        key_code  = 8'h07; step(2);  // R04: now full
        evt_ready = 1'b1;
        step(1);                      // P07 pushed while head pops
        n_checks++; if (overflow !== 1'b0) $display("FAIL full_pop_ovf got %b want 0", overflow); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (evt_valid !== 1'b1 || evt_data !== exp_q[i]) $display("FAIL full_pop%0d got v=%b d=%h want v=1 d=%h", i, evt_valid, evt_data, exp_q[i]); else n_pass++;
            step(1);
        end
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL full_pop_empty got %b want 0", evt_valid); else n_pass++;
    endtask

    task automatic test_toggle();
        logic [9:0] exp_q [4];
        exp_q = '{10'h107, 10'h207, 10'h116, 10'h216};
        do_reset();
        evt_ready = 1'b0;
        key_code  = 8'h07; step(3);  // P07, one HOLD cycle
        key_code  = 8'h16; step(1);  // HOLD -> RELEASE, pending 16
        key_code  = 8'h00; step(1);  // R07 pushed; change ignored
        step(1);                      // P16 pushed
        n_checks++; if (held_code !== 8'h16) $display("FAIL toggle_mid_held got %h want 16", held_code); else n_pass++;
        step(2);                      // HOLD sees 00, R16 pushed
        n_checks++; if (held_code !== 8'h00 || overflow !== 1'b0) $display("FAIL toggle_end got held=%h ovf=%b want 00/0", held_code, overflow); else n_pass++;
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (evt_valid !== 1'b1 || evt_data !== exp_q[i]) $display("FAIL toggle%0d got v=%b d=%h want v=1 d=%h", i, evt_valid, evt_data, exp_q[i]); else n_pass++;
            step(1);
        end
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL toggle_empty got %b want 0", evt_valid); else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        evt_ready = 1'b0;
        key_code  = 8'h1A;
        step(10);  // P1A at E1, repeat at E9
        n_checks++; if (evt_valid !== 1'b1 || evt_data !== 10'h11A) $display("FAIL rst_hold_pre got v=%b d=%h want v=1 d=11a", evt_valid, evt_data); else n_pass++;
        reset_n = 1'b0;
        step(1);
        n_checks++; if (evt_valid !== 1'b0 || evt_data !== 10'h000) $display("FAIL rst_hold_fifo got v=%b d=%h want v=0 d=000", evt_valid, evt_data); else n_pass++;
        n_checks++; if (held_code !== 8'h00 || dir !== 4'b0000) $display("FAIL rst_hold_held got %h/%b want 00/0000", held_code, dir); else n_pass++;
        reset_n = 1'b1;
        step(1);  // IDLE -> PRESS, nothing pushed
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL rst_hold_norel got %b want 0", evt_valid); else n_pass++;
        step(1);
        n_checks++; if (evt_valid !== 1'b1 || evt_data !== 10'h11A) $display("FAIL rst_hold_repress got v=%b d=%h want v=1 d=11a", evt_valid, evt_data); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_press_repeat();
        test_release_press();
        test_overflow();
        test_full_pop();
        test_toggle();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
